spi_master_xfer: RTL and testbench
==================================

Name: spi_master_xfer

Overview:
- Byte-oriented SPI master shift engine that sits directly upstream of the management SoC's spi_sck/spi_csb/spi_sdo/spi_sdi/spi_sdoenb pins. It drives the external SPI slave, for example the second test flash on the SPI pins.
- A CSR/Wishbone front end supplies one byte per request over a valid/ready handshake. The engine returns the received byte with a one-cycle strobe.
- The engine handles clock division, CPOL/CPHA modes, bit order and chip-select framing across multi-byte commands, such as a 0x03 read of a test pattern.

Parameters:
- DIV_W, 16, width of the clock divider field.
- CS_GAP, 2, minimum number of sys_clk cycles that CSB is held high between frames.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, synchronous and active-high.
- cfg_div  in  DIV_W  SCK half-period minus 1, in sys_clk cycles.
- cfg_cpol  in  1  SCK idle level.
- cfg_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- cfg_lsb_first  in  1  bit order.
- tx_valid  in  1  request carries a byte to transfer.
- tx_ready  out  1  engine accepts a request.
- tx_data  in  8  byte to shift out.
- tx_last  in  1  deassert CSB after this byte.
- rx_valid  out  1  one-cycle strobe that rx_data is valid.
- rx_data  out  8  byte received.
- busy  out  1  a frame is in progress (CSB low or CS gap running).
- spi_sck  out  1  serial clock.
- spi_csb  out  1  chip select, active-low.
- spi_sdo  out  1  master data out.
- spi_sdi  in  1  master data in.
- spi_sdoenb  out  1  output enable for spi_sdo, active-low.

Behaviour:
- Reset values (while sys_rst=1, sampled at the sys_clk edge):
  - spi_csb=1, spi_sck=cfg_cpol, spi_sdo=0, spi_sdoenb=1.
  - tx_ready=0, rx_valid=0, rx_data=0, busy=0.
  - State goes to IDLE.
  - Reset asserted mid-byte aborts the byte: CSB rises on the next edge and no rx_valid is produced.
- cfg_* values are sampled when a byte is accepted and are held constant for that byte.
- States: IDLE, LEAD, SHIFT, NEXT, TRAIL, GAP.
- IDLE:
  - tx_ready=1.
  - On tx_valid&tx_ready, latch tx_data and tx_last, drive spi_csb=0 and spi_sdoenb=0, then go to LEAD.
- LEAD:
  - Wait one half-period (cfg_div+1 cycles) for CS setup.
  - If cfg_cpha=0, the first bit is already on spi_sdo when CSB falls.
  - Then go to SHIFT.
- SHIFT:
  - A half-period counter reloads at cfg_div and toggles spi_sck each time it reaches 0.
  - 16 toggles make one byte.
  - cpha=0: sample spi_sdi on odd toggles; update spi_sdo on even toggles, excluding the final one.
  - cpha=1: update spi_sdo on odd toggles; sample spi_sdi on even toggles.
  - Bit order is MSB first unless cfg_lsb_first=1.
  - After the 16th toggle, spi_sck equals cfg_cpol.
  - rx_data is updated and rx_valid pulses for one cycle in the cycle after the final sample.
- NEXT (entered when !tx_last):
  - CSB stays low and tx_ready=1.
  - On a handshake, go directly to SHIFT with no LEAD delay, so bytes are back to back with a one-cycle bubble.
  - If tx_valid is low, CSB is held low indefinitely with SCK idle.
- TRAIL (entered when tx_last):
  - Hold one half-period, then set spi_csb=1 and spi_sdoenb=1, then go to GAP.
- GAP:
  - Hold CS_GAP cycles with tx_ready=0, then go to IDLE.
- Counter rules:
  - cfg_div=0 gives SCK = sys_clk/2.
  - The divider counter is DIV_W bits and never wraps mid-half-period.
  - The bit counter is 4 bits, counting 0..15.
- tx_ready is a registered output and is never 1 in LEAD, SHIFT, TRAIL or GAP.
- A tx_valid that arrives while tx_ready=0 is held by the requester, per standard valid/ready rules.
- busy=1 in every state except IDLE.

Decomposition:
- Package spi_master_pkg:
  - State enum spi_state_e.
  - Localparams BITS_PER_BYTE=8 and EDGES_PER_BYTE=16.
- One natural sub-module: spi_clkgen. It holds the half-period counter and the edge/toggle generator, with outputs edge_lead and edge_trail.
- The shift registers and the FSM stay in the top module.

Test Plan:
- Mode 0, cfg_div=1, send 0x03 with tx_last=1; slave returns 0x93:
  - spi_sdo shows 00000011 MSB first.
  - SCK period is 4 sys_clk cycles.
  - rx_data=0x93 with a single rx_valid pulse.
  - CSB is high for at least 2 cycles afterwards.
- Four-byte frame {0x03,0x00,0x00,0x00}, then 8 reads, with tx_last only on the final byte:
  - CSB stays low throughout.
  - rx bytes match the test_data pattern 0x93,0x01,0x00,0x13,0x02,0x63,0x57,0xB5.
- Mode 3 (cpol=1, cpha=1), cfg_lsb_first=1, send 0xA5:
  - SCK idles high.
  - spi_sdo sequence is 1,0,1,0,0,1,0,1.
  - Loopback spi_sdi=spi_sdo yields rx_data=0xA5.
- cfg_div=0 back-to-back bytes with tx_valid held high:
  - Exactly one idle sys_clk cycle between bytes.
  - tx_ready is asserted only in IDLE or NEXT.
- sys_rst asserted at toggle 7 of a byte:
  - Next cycle shows spi_csb=1, spi_sck=cpol, rx_valid=0.
  - A new transfer afterwards completes correctly.
- NEXT stall, with tx_valid low for 50 cycles:
  - CSB stays low and SCK stays static.
  - The next byte then shifts correctly.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared state type, byte geometry and bit-order helpers for the SPI master shift engine.
package spi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT,
      ST_NEXT,
      ST_TRAIL,
      ST_GAP
   } spi_state_e;

   localparam int BITS_PER_BYTE  = 8;
   localparam int EDGES_PER_BYTE = 16;

   function automatic logic first_bit(input logic [BITS_PER_BYTE-1:0] d, input logic lsb_first);
      return lsb_first ? d[0] : d[BITS_PER_BYTE-1];
   endfunction

   function automatic logic [BITS_PER_BYTE-1:0] shift_byte(input logic [BITS_PER_BYTE-1:0] d,
                                                          input logic lsb_first);
      return lsb_first ? {1'b0, d[BITS_PER_BYTE-1:1]} : {d[BITS_PER_BYTE-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period divider and SCK toggle counter; flags leading and trailing SCK edges.
module spi_clkgen #(
   parameter int DIV_W = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   input  logic             tgl_en,
   output logic             hp_done,
   output logic             edge_lead,
   output logic             edge_trail,
   output logic [3:0]       tgl_idx
);

   logic [DIV_W-1:0] cnt_reg;
   logic [3:0]       tgl_reg;

   // Counter reloads from div on expiry, so a half-period is always div+1 cycles.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_reg <= '0;
      end else if (load || (cnt_reg == '0)) begin
         cnt_reg <= div;
      end else begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst || load) begin
         tgl_reg <= '0;
      end else if (tgl_en && hp_done) begin
         tgl_reg <= tgl_reg + 4'd1;
      end
   end

   assign hp_done    = !load && (cnt_reg == '0);
   assign edge_lead  = tgl_en && hp_done && !tgl_reg[0];
   assign edge_trail = tgl_en && hp_done &&  tgl_reg[0];
   assign tgl_idx    = tgl_reg;

endmodule

// File: rtl/spi_master_xfer.sv
// Byte-oriented SPI master: valid/ready byte requests in, CPOL/CPHA shifting with CS framing out.
module spi_master_xfer #(
   parameter int DIV_W  = 16,
   parameter int CS_GAP = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_cpol,
   input  logic             cfg_cpha,
   input  logic             cfg_lsb_first,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [7:0]       tx_data,
   input  logic             tx_last,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   output logic             busy,
   output logic             spi_sck,
   output logic             spi_csb,
   output logic             spi_sdo,
   input  logic             spi_sdi,
   output logic             spi_sdoenb
);
   import spi_master_pkg::*;

   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   spi_state_e       state_reg, state_next;
   logic             accept;
   logic [DIV_W-1:0] div_reg;
   logic             cpol_reg, cpha_reg, lsb_reg, last_reg;
   logic [7:0]       tx_sr_reg, rx_sr_reg, rx_data_reg, rx_shifted;
   logic             rx_valid_reg, tx_ready_reg;
   logic             sck_reg, csb_reg, sdo_reg, sdoenb_reg;
   logic [GAP_W-1:0] gap_cnt_reg;

   logic             clk_load, hp_done, edge_lead, edge_trail;
   logic [DIV_W-1:0] clk_div;
   logic [3:0]       tgl_idx;
   logic             sample, update, final_sample, final_tgl;

   assign clk_load = (state_reg == ST_IDLE) || (state_reg == ST_NEXT) || (state_reg == ST_GAP);
   assign clk_div  = clk_load ? cfg_div : div_reg;

   spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .load       (clk_load),
      .div        (clk_div),
      .tgl_en     (state_reg == ST_SHIFT),
      .hp_done    (hp_done),
      .edge_lead  (edge_lead),
      .edge_trail (edge_trail),
      .tgl_idx    (tgl_idx)
   );

   // cpha=0 samples on leading edges; the final trailing edge never shifts out a new bit.
   assign sample       = cpha_reg ? edge_trail : edge_lead;
   assign update       = cpha_reg ? edge_lead : (edge_trail && (tgl_idx != 4'(EDGES_PER_BYTE-1)));
   assign final_sample = sample && (tgl_idx[3:1] == 3'b111);
   assign final_tgl    = edge_trail && (tgl_idx == 4'(EDGES_PER_BYTE-1));
   assign rx_shifted   = lsb_reg ? {spi_sdi, rx_sr_reg[7:1]} : {rx_sr_reg[6:0], spi_sdi};

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = tx_valid && tx_ready_reg;
      case (state_reg)
         ST_IDLE:  if (accept)              state_next = ST_LEAD;
         ST_LEAD:  if (hp_done)             state_next = ST_SHIFT;
         ST_SHIFT: if (final_tgl)           state_next = last_reg ? ST_TRAIL : ST_NEXT;
         ST_NEXT:  if (accept)              state_next = ST_SHIFT;
         ST_TRAIL: if (hp_done)             state_next = ST_GAP;
         ST_GAP:   if (gap_cnt_reg == '0)   state_next = ST_IDLE;
         default:                           state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         div_reg      <= '0;
         cpol_reg     <= 1'b0;
         cpha_reg     <= 1'b0;
         lsb_reg      <= 1'b0;
         last_reg     <= 1'b0;
         tx_sr_reg    <= '0;
         rx_sr_reg    <= '0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         tx_ready_reg <= 1'b0;
         sck_reg      <= cfg_cpol;
         csb_reg      <= 1'b1;
         sdo_reg      <= 1'b0;
         sdoenb_reg   <= 1'b1;
         gap_cnt_reg  <= '0;
      end else begin
         rx_valid_reg <= 1'b0;
         tx_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_NEXT);
         if (state_reg == ST_IDLE) begin
            sck_reg <= cfg_cpol;
         end
         if (accept) begin
            div_reg    <= cfg_div;
            cpol_reg   <= cfg_cpol;
            cpha_reg   <= cfg_cpha;
            lsb_reg    <= cfg_lsb_first;
            last_reg   <= tx_last;
            sck_reg    <= cfg_cpol;
            csb_reg    <= 1'b0;
            sdoenb_reg <= 1'b0;
            rx_sr_reg  <= '0;
            // cpha=0 needs the first bit valid before the first (sampling) edge.
            if (!cfg_cpha) begin
               sdo_reg   <= first_bit(tx_data, cfg_lsb_first);
               tx_sr_reg <= shift_byte(tx_data, cfg_lsb_first);
            end else begin
               tx_sr_reg <= tx_data;
            end
         end
         if (state_reg == ST_SHIFT) begin
            if (hp_done) begin
               sck_reg <= ~sck_reg;
            end
            if (update) begin
               sdo_reg   <= first_bit(tx_sr_reg, lsb_reg);
               tx_sr_reg <= shift_byte(tx_sr_reg, lsb_reg);
            end
            if (sample) begin
               rx_sr_reg <= rx_shifted;
               if (final_sample) begin
                  rx_data_reg  <= rx_shifted;
                  rx_valid_reg <= 1'b1;
               end
            end
         end
         if ((state_reg == ST_TRAIL) && hp_done) begin
            csb_reg     <= 1'b1;
            sdoenb_reg  <= 1'b1;
            gap_cnt_reg <= GAP_W'(CS_GAP - 1);
         end
         if ((state_reg == ST_GAP) && (gap_cnt_reg != '0)) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
         end
      end
   end

   assign tx_ready   = tx_ready_reg;
   assign rx_valid   = rx_valid_reg;
   assign rx_data    = rx_data_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign spi_sck    = sck_reg;
   assign spi_csb    = csb_reg;
   assign spi_sdo    = sdo_reg;
   assign spi_sdoenb = sdoenb_reg;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer with a pin-level mode-0 slave model and optional loopback.
module tb_spi_master_xfer;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [15:0] cfg_div;
   logic        cfg_cpol, cfg_cpha, cfg_lsb_first;
   logic        tx_valid, tx_ready, tx_last;
   logic [7:0]  tx_data, rx_data;
   logic        rx_valid, busy;
   logic        spi_sck, spi_csb, spi_sdo, spi_sdi, spi_sdoenb;
   logic        loopback;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 sys_clk = ~sys_clk;

   spi_master_xfer #(.DIV_W(16), .CS_GAP(2)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .cfg_div       (cfg_div),
      .cfg_cpol      (cfg_cpol),
      .cfg_cpha      (cfg_cpha),
      .cfg_lsb_first (cfg_lsb_first),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_data       (tx_data),
      .tx_last       (tx_last),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .busy          (busy),
      .spi_sck       (spi_sck),
      .spi_csb       (spi_csb),
      .spi_sdo       (spi_sdo),
      .spi_sdi       (spi_sdi),
      .spi_sdoenb    (spi_sdoenb)
   );

   // Pin monitor and slave model: everything observed at the falling sys_clk edge.
   logic [7:0] resp [0:15];
   logic [7:0] pat  [0:7];
   logic [7:0] rx_q [$];
   int         tgl_q [$];
   int         cyc = 0;
   logic       prev_csb = 1'b1, prev_sck = 1'b0, prev_ready = 1'b0;
   int         csb_hi_run = 0, last_gap = 0, csb_rises = 0;
   int         fall_cyc = 0, rise_cyc = 0, rise_prev = 0, rise_last = 0, bad_ready = 0;
   logic [3:0] s_idx = '0;
   logic [2:0] s_bit = '0;
   logic [7:0] s_rx = '0;
   logic       slave_sdi = 1'b0;

   assign spi_sdi = loopback ? spi_sdo : slave_sdi;

   always @(negedge sys_clk) begin
      cyc = cyc + 1;
      if (rx_valid) rx_q.push_back(rx_data);
      if (prev_csb && !spi_csb) begin
         s_idx     = '0;
         s_bit     = '0;
         slave_sdi = resp[0][7];
         fall_cyc  = cyc;
         last_gap  = csb_hi_run;
      end
      if (!prev_csb && spi_csb) begin
         csb_rises = csb_rises + 1;
         rise_cyc  = cyc;
      end
      if (!spi_csb && (spi_sck != prev_sck)) begin
         tgl_q.push_back(cyc);
         if (spi_sck) begin
            s_rx      = {s_rx[6:0], spi_sdo};
            rise_prev = rise_last;
            rise_last = cyc;
         end else begin
            s_bit = s_bit + 3'd1;
            if (s_bit == 3'd0) s_idx = s_idx + 4'd1;
            slave_sdi = resp[s_idx][3'd7 - s_bit];
         end
      end
      if (prev_ready && !spi_csb && (spi_sck != prev_sck)) bad_ready = bad_ready + 1;
      if (tx_ready && spi_csb && busy) bad_ready = bad_ready + 1;
      csb_hi_run = spi_csb ? csb_hi_run + 1 : 0;
      prev_csb   = spi_csb;
      prev_sck   = spi_sck;
      prev_ready = tx_ready;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      tx_last  = l;
      while (!tx_ready && n < 5000) begin
         step();
         n++;
      end
      check("tx_handshake", tx_ready, 1);
      step();
      $display("tx byte 0x%02h last=%0d accepted at cycle %0d", d, l, cyc);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin
         step();
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   int rx_base, tgl_base, rise0, stall_bad;

   initial begin
      sys_rst = 1'b1; cfg_div = 16'd1; cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; loopback = 1'b0;
      for (int i = 0; i < 16; i++) resp[i] = 8'hFF;
      pat = '{8'h93, 8'h01, 8'h00, 8'h13, 8'h02, 8'h63, 8'h57, 8'hB5};

      // Reset values
      repeat (3) step();
      check("rst_sck_cpol1", spi_sck, 1);
      cfg_cpol = 1'b0;
      step();
      check("rst_sck_cpol0", spi_sck, 0);
      check("rst_csb", spi_csb, 1);
      check("rst_sdo", spi_sdo, 0);
      check("rst_sdoenb", spi_sdoenb, 1);
      check("rst_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      sys_rst = 1'b0;
      step();
      check("ready_after_rst", tx_ready, 1);

      // Mode 0, div=1, single byte 0x03, slave answers 0x93
      resp[0] = 8'h93;
      rx_base = rx_q.size(); tgl_base = tgl_q.size();
      send_byte(8'h03, 1'b1);
      tx_valid = 1'b0;
      check("t1_csb_low", spi_csb, 0);
      check("t1_sdoenb_low", spi_sdoenb, 0);
      check("t1_busy", busy, 1);
      check("t1_ready_lead", tx_ready, 0);
      wait_idle();
      check("t1_sdo_bits", s_rx, 8'h03);
      check("t1_toggles", tgl_q.size() - tgl_base, 16);
      check("t1_sck_period", rise_last - rise_prev, 4);
      check("t1_lead_time", tgl_q[tgl_base] - fall_cyc, 4);
      check("t1_trail_time", rise_cyc - tgl_q[tgl_base+15], 2);
      check("t1_rx_count", rx_q.size() - rx_base, 1);
      check("t1_rx_data", rx_q[rx_base], 8'h93);
      check("t1_csb_high", spi_csb, 1);
      check("t1_sdoenb_high", spi_sdoenb, 1);
      $display("t1 rx=0x%02h sdo=0x%02h", rx_q[rx_base], s_rx);

      // 0x03 read: 4 command bytes then 8 data bytes in one CS frame
      for (int i = 0; i < 8; i++) resp[4+i] = pat[i];
      rx_base = rx_q.size(); rise0 = csb_rises;
      for (int i = 0; i < 12; i++) send_byte((i == 0) ? 8'h03 : 8'h00, i == 11);
      tx_valid = 1'b0;
      wait_idle();
      check("t2_cs_gap_min", last_gap >= 2, 1);
      check("t2_csb_rises", csb_rises - rise0, 1);
      check("t2_rx_count", rx_q.size() - rx_base, 12);
      if (rx_q.size() >= rx_base + 12) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_rx%0d", i), rx_q[rx_base+4+i], pat[i]);
            $display("t2 read byte %0d rx=0x%02h", i, rx_q[rx_base+4+i]);
         end
      end

      // Mode 3, LSB first, loopback 0xA5
      cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_lsb_first = 1'b1; loopback = 1'b1;
      step(); step();
      check("t3_sck_idle_high", spi_sck, 1);
      rx_base = rx_q.size();
      send_byte(8'hA5, 1'b1);
      tx_valid = 1'b0;
      wait_idle();
      check("t3_sdo_seq", s_rx, 8'hA5);
      check("t3_rx_count", rx_q.size() - rx_base, 1);
      check("t3_rx_data", rx_q[rx_base], 8'hA5);
      check("t3_sck_end_high", spi_sck, 1);
      $display("t3 rx=0x%02h sdo_seq=0x%02h", rx_q[rx_base], s_rx);

      // div=0 back-to-back, valid held high
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; loopback = 1'b0; cfg_div = 16'd0;
      resp[0] = 8'h3C; resp[1] = 8'hC3; resp[2] = 8'h5A;
      step(); step();
      rx_base = rx_q.size(); tgl_base = tgl_q.size();
      send_byte(8'hF0, 1'b0);
      send_byte(8'h0F, 1'b0);
      send_byte(8'hAA, 1'b1);
      tx_valid = 1'b0;
      wait_idle();
      check("t4_toggles", tgl_q.size() - tgl_base, 48);
      if (tgl_q.size() >= tgl_base + 48) begin
         check("t4_inbyte_gap", tgl_q[tgl_base+15] - tgl_q[tgl_base+14], 1);
         check("t4_bubble01", tgl_q[tgl_base+16] - tgl_q[tgl_base+15], 2);
         check("t4_bubble12", tgl_q[tgl_base+32] - tgl_q[tgl_base+31], 2);
      end
      check("t4_rx_count", rx_q.size() - rx_base, 3);
      check("t4_rx0", rx_q[rx_base], 8'h3C);
      check("t4_rx1", rx_q[rx_base+1], 8'hC3);
      check("t4_rx2", rx_q[rx_base+2], 8'h5A);
      check("t4_sdo_last", s_rx, 8'hAA);

      // Reset at toggle 7, then a clean transfer
      cfg_div = 16'd1;
      resp[0] = 8'hFF;
      rx_base = rx_q.size(); tgl_base = tgl_q.size();
      send_byte(8'h55, 1'b1);
      tx_valid = 1'b0;
      for (int n = 0; n < 200 && (tgl_q.size() - tgl_base) < 7; n++) step();
      check("t5_reach_tgl7", tgl_q.size() - tgl_base, 7);
      sys_rst = 1'b1;
      step();
      check("t5_csb", spi_csb, 1);
      check("t5_sck", spi_sck, 0);
      check("t5_rx_valid", rx_valid, 0);
      check("t5_busy", busy, 0);
      sys_rst = 1'b0;
      repeat (20) step();
      check("t5_no_rx", rx_q.size() - rx_base, 0);
      resp[0] = 8'hC3;
      send_byte(8'h5A, 1'b1);
      tx_valid = 1'b0;
      wait_idle();
      check("t5_rx_count", rx_q.size() - rx_base, 1);
      check("t5_rx_data", rx_q[rx_base], 8'hC3);
      check("t5_sdo", s_rx, 8'h5A);

      // NEXT stall for 50 cycles
      resp[0] = 8'h11; resp[1] = 8'hEE;
      rx_base = rx_q.size();
      send_byte(8'h9F, 1'b0);
      tx_valid = 1'b0;
      for (int n = 0; n < 200 && !tx_ready; n++) step();
      check("t6_reach_next", tx_ready, 1);
      stall_bad = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (spi_csb !== 1'b0 || spi_sck !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
      end
      check("t6_stall_static", stall_bad, 0);
      send_byte(8'h6C, 1'b1);
      tx_valid = 1'b0;
      wait_idle();
      check("t6_rx_count", rx_q.size() - rx_base, 2);
      check("t6_rx0", rx_q[rx_base], 8'h11);
      check("t6_rx1", rx_q[rx_base+1], 8'hEE);
      check("t6_sdo", s_rx, 8'h6C);

      check("ready_only_idle_next", bad_ready, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
